instr_issue: RTL and testbench

INSTR_ISSUE -- requirements
Module: instr_issue

---
 rtl/instr_issue_pkg.sv | 33 +++
 rtl/instr_issue_decode.sv | 33 +++
 rtl/instr_issue.sv | 116 +++++++++++
 tb/tb_instr_issue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction fetch/decode/issue block:
// opcodes, instruction field positions, FSM encoding and the control-word layout.
package instr_issue_pkg;

    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       write;
    } cw_t;

endpackage

// File: rtl/instr_issue_decode.sv
// Combinational instruction decode: splits the instruction register into a
// control word and flags the two control-flow opcodes.
module instr_decode
    import instr_issue_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [15:0]     ir,
    output cw_t             cw,
    output logic            is_jmp,
    output logic            is_halt,
    output logic [PC_W-1:0] jmp_target
);

    logic [7:0] target_raw;

    always_comb begin
        cw       = '0;
        cw.sel   = ir[OP_MSB:OP_LSB];
        cw.rd    = ir[RD_MSB:RD_LSB];
        cw.rs1   = ir[RS1_MSB:RS1_LSB];
        cw.rs2   = ir[RS2_MSB:RS2_LSB];
        // r0 is never written
        cw.write = (ir[RD_MSB:RD_LSB] != 4'd0);
    end

    assign is_jmp     = (ir[OP_MSB:OP_LSB] == OP_JMP);
    assign is_halt    = (ir[OP_MSB:OP_LSB] == OP_HALT);
    assign target_raw = {ir[RS1_MSB:RS1_LSB], ir[RS2_MSB:RS2_LSB]};
    // size cast truncates or zero-extends the 8-bit target to the PC width
    assign jmp_target = PC_W'(target_raw);

endmodule

// File: rtl/instr_issue.sv
// Instruction issue sequencer: fetches one 16-bit instruction, decodes it and
// hands a control word to the register bank / ALU controller via valid/ready.
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic            cw_valid,
    input  logic            cw_ready,
    output logic [3:0]      cw_sel,
    output logic [3:0]      cw_rd,
    output logic [3:0]      cw_rs1,
    output logic [3:0]      cw_rs2,
    output logic            cw_write,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    state_t          state;
    logic [15:0]     ir;
    cw_t             cw_q;
    cw_t             dec_cw;
    logic            dec_jmp;
    logic            dec_halt;
    logic [PC_W-1:0] dec_target;

    instr_decode #(.PC_W(PC_W)) u_decode (
        .ir         (ir),
        .cw         (dec_cw),
        .is_jmp     (dec_jmp),
        .is_halt    (dec_halt),
        .jmp_target (dec_target)
    );

    // Status outputs are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= START_PC;
            ir       <= '0;
            cw_q     <= '0;
            imem_req <= 1'b0;
            cw_valid <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc       <= START_PC;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        state    <= S_DECODE;
                        imem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (dec_halt) begin
                        state  <= S_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (dec_jmp) begin
                        pc       <= dec_target;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        cw_q     <= dec_cw;
                        state    <= S_ISSUE;
                        cw_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // cw_q is left untouched so the fields keep the last issued word
                    if (cw_ready) begin
                        pc       <= pc + PC_W'(1);
                        state    <= S_FETCH;
                        cw_valid <= 1'b0;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    cw_valid <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign cw_sel    = cw_q.sel;
    assign cw_rd     = cw_q.rd;
    assign cw_rs1    = cw_q.rs1;
    assign cw_rs2    = cw_q.rs2;
    assign cw_write  = cw_q.write;

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed scenarios plus randomized programs checked
// against an instruction-level model of fetch order and issued control words.
module tb_instr_issue;

    localparam int         PC_W     = 8;
    localparam logic [7:0] START_PC = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic        cw_ready = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        imem_req, cw_valid, cw_write, busy, halted;
    logic [7:0]  imem_addr, pc;
    logic [3:0]  cw_sel, cw_rd, cw_rs1, cw_rs2;

    logic [15:0] mem [0:255];
    logic [7:0]  m_pc;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    instr_issue #(.PC_W(PC_W), .START_PC(START_PC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .cw_valid(cw_valid), .cw_ready(cw_ready),
        .cw_sel(cw_sel), .cw_rd(cw_rd), .cw_rs1(cw_rs1), .cw_rs2(cw_rs2), .cw_write(cw_write),
        .pc(pc), .busy(busy), .halted(halted)
    );

    task automatic fill_mem(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; imem_ack = 1'b0; cw_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs a program from START_PC. The model walks the program at instruction
    // level: every acked fetch yields one instruction, which two cycles later must
    // show up as an issued word, a jump-target fetch or the halted state.
    task automatic run_prog(input int cycles, input int max_dly, input int rdy_pct,
                            output int words, output bit done);
        int          dly, since;
        logic [15:0] cur;
        logic [16:0] exp_f;
        bit          cw_open, hs_pend;
        words = 0; done = 1'b0; since = -1; cw_open = 1'b0; hs_pend = 1'b0;
        cur = 16'h0; exp_f = 17'h0;
        dly = $urandom_range(max_dly, 0);
        m_pc = START_PC;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < cycles && !done; c++) begin
            @(negedge clk);
            start = 1'b0; imem_ack = 1'b0; cw_ready = 1'b0; imem_data = 16'($urandom);
            if (since >= 0) since++;
            if (hs_pend) begin
                hs_pend = 1'b0; cw_open = 1'b0; words++; m_pc = m_pc + 8'd1;
                compared++;
                if ({imem_req, cw_valid, pc} !== {1'b1, 1'b0, m_pc}) begin
                    $display("FAIL next_fetch: req=%b valid=%b pc=%h, expected req=1 valid=0 pc=%h",
                             imem_req, cw_valid, pc, m_pc);
                    mismatched++;
                end
            end
            if (since == 1) begin
                compared++;
                if ({busy, imem_req, cw_valid, halted} !== 4'b1000) begin
                    $display("FAIL decode_cycle: busy/req/valid/halted=%b, expected 1000",
                             {busy, imem_req, cw_valid, halted});
                    mismatched++;
                end
            end else if (since == 2) begin
                since = -1;
                if (cur[15:12] == 4'hF) begin
                    done = 1'b1;
                    compared++;
                    if ({halted, busy, imem_req, cw_valid} !== 4'b1000) begin
                        $display("FAIL halt: halted/busy/req/valid=%b, expected 1000",
                                 {halted, busy, imem_req, cw_valid});
                        mismatched++;
                    end
                end else if (cur[15:12] == 4'hE) begin
                    m_pc = cur[7:0];
                    compared++;
                    if ({imem_req, cw_valid, imem_addr} !== {2'b10, m_pc}) begin
                        $display("FAIL jmp: req=%b valid=%b addr=%h, expected req=1 valid=0 addr=%h",
                                 imem_req, cw_valid, imem_addr, m_pc);
                        mismatched++;
                    end
                end else begin
                    cw_open = 1'b1;
                    exp_f = {cur, (cur[11:8] != 4'd0)};
                end
            end
            compared++;
            if (cw_open) begin
                if ({cw_valid, cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write} !== {1'b1, exp_f}) begin
                    $display("FAIL cw_word: valid=%b word=%h, expected valid=1 word=%h",
                             cw_valid, {cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write}, exp_f);
                    mismatched++;
                end
            end else if (cw_valid !== 1'b0) begin
                $display("FAIL spurious_valid: valid=%b, expected 0", cw_valid);
                mismatched++;
            end
            // memory responder with random wait states; stray acks must be ignored
            if (imem_req === 1'b1) begin
                compared++;
                if ({busy, imem_addr} !== {1'b1, m_pc}) begin
                    $display("FAIL fetch_addr: busy=%b addr=%h, expected busy=1 addr=%h",
                             busy, imem_addr, m_pc);
                    mismatched++;
                end
                if (dly == 0) begin
                    imem_ack = 1'b1; cur = mem[m_pc]; imem_data = cur; since = 0;
                    dly = $urandom_range(max_dly, 0);
                end else begin
                    dly--;
                end
            end else if ($urandom_range(3, 0) == 0) begin
                imem_ack = 1'b1;
            end
            if (cw_open && cw_valid === 1'b1) begin
                if ($urandom_range(99, 0) < rdy_pct) begin
                    cw_ready = 1'b1; hs_pend = 1'b1;
                end
            end else begin
                cw_ready = 1'($urandom_range(1, 0));
            end
            if (busy === 1'b1 && !done && $urandom_range(7, 0) == 0) start = 1'b1;
        end
        start = 1'b0; imem_ack = 1'b0; cw_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        compared++;
        if ({imem_req, cw_valid, busy, halted, cw_write} !== 5'b0) begin
            $display("FAIL reset_ctl: req/valid/busy/halted/write=%b, expected 00000",
                     {imem_req, cw_valid, busy, halted, cw_write});
            mismatched++;
        end
        compared++;
        if ({cw_sel, cw_rd, cw_rs1, cw_rs2} !== 16'h0) begin
            $display("FAIL reset_fields: %h, expected 0000", {cw_sel, cw_rd, cw_rs1, cw_rs2});
            mismatched++;
        end
        compared++;
        if ({pc, imem_addr} !== {START_PC, START_PC}) begin
            $display("FAIL reset_pc: pc=%h addr=%h, expected %h", pc, imem_addr, START_PC);
            mismatched++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        compared++;
        if ({imem_req, busy, halted, cw_valid} !== 4'b0) begin
            $display("FAIL idle_hold: req/busy/halted/valid=%b, expected 0000",
                     {imem_req, busy, halted, cw_valid});
            mismatched++;
        end
    endtask

    task automatic test_latency();
        do_reset();
        mem[0] = 16'h1415;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        compared++;
        if ({imem_req, busy, imem_addr} !== {2'b11, 8'h00}) begin
            $display("FAIL lat_fetch: req=%b busy=%b addr=%h, expected 1 1 00", imem_req, busy, imem_addr);
            mismatched++;
        end
        imem_ack = 1'b1; imem_data = mem[0];
        @(negedge clk); imem_ack = 1'b0;
        compared++;
        if ({imem_req, cw_valid, busy} !== 3'b001) begin
            $display("FAIL lat_decode: req/valid/busy=%b, expected 001", {imem_req, cw_valid, busy});
            mismatched++;
        end
        @(negedge clk);
        compared++;
        if ({cw_valid, cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write} !== {1'b1, 4'h1, 4'h4, 4'h1, 4'h5, 1'b1}) begin
            $display("FAIL lat_issue: valid=%b word=%h, expected valid=1 word=%h", cw_valid,
                     {cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write}, {4'h1, 4'h4, 4'h1, 4'h5, 1'b1});
            mismatched++;
        end
        cw_ready = 1'b1;
        @(negedge clk); cw_ready = 1'b0;
        compared++;
        if ({pc, imem_req, cw_valid} !== {8'h01, 2'b10}) begin
            $display("FAIL lat_handshake: pc=%h req=%b valid=%b, expected 01 1 0", pc, imem_req, cw_valid);
            mismatched++;
        end
        compared++;
        if ({cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write} !== {4'h1, 4'h4, 4'h1, 4'h5, 1'b1}) begin
            $display("FAIL cw_hold: word=%h, expected %h", {cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write},
                     {4'h1, 4'h4, 4'h1, 4'h5, 1'b1});
            mismatched++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem[0] = 16'h0012;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; imem_ack = 1'b1; imem_data = mem[0];
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({cw_valid, cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write, pc} !==
                {1'b1, 4'h0, 4'h0, 4'h1, 4'h2, 1'b0, 8'h00}) begin
                $display("FAIL stall_hold[%0d]: valid=%b word=%h pc=%h, expected 1 %h 00", i, cw_valid,
                         {cw_sel, cw_rd, cw_rs1, cw_rs2, cw_write}, pc, {4'h0, 4'h0, 4'h1, 4'h2, 1'b0});
                mismatched++;
            end
            @(negedge clk);
        end
        cw_ready = 1'b1;
        @(negedge clk); cw_ready = 1'b0;
        compared++;
        if ({pc, cw_valid} !== {8'h01, 1'b0}) begin
            $display("FAIL stall_release: pc=%h valid=%b, expected 01 0", pc, cw_valid);
            mismatched++;
        end
    endtask

    task automatic test_jmp();
        int w; bit d;
        do_reset();
        fill_mem(16'hF000);
        mem[0] = 16'hE02A; mem[8'h2A] = 16'h2345;
        run_prog(80, 2, 100, w, d);
        compared++;
        if (!(d && w == 1)) begin
            $display("FAIL jmp_prog: halted=%b words=%0d, expected halted=1 words=1", d, w);
            mismatched++;
        end
    endtask

    task automatic test_wrap();
        int w; bit d;
        do_reset();
        fill_mem(16'hF000);
        mem[0] = 16'hE0FF; mem[8'hFF] = 16'h1234;
        run_prog(40, 0, 100, w, d);
        compared++;
        if (d || w < 2) begin
            $display("FAIL wrap: halted=%b words=%0d, expected halted=0 words>=2", d, w);
            mismatched++;
        end
    endtask

    task automatic test_halt();
        int w; bit d;
        do_reset();
        fill_mem(16'hF000);
        mem[0] = 16'h1111; mem[1] = 16'h2220; mem[2] = 16'h3003;
        run_prog(200, 3, 70, w, d);
        compared++;
        if (!(d && w == 3)) begin
            $display("FAIL halt_prog: halted=%b words=%0d, expected halted=1 words=3", d, w);
            mismatched++;
        end
        repeat (4) begin
            @(negedge clk);
            compared++;
            if ({imem_req, busy, halted} !== 3'b001) begin
                $display("FAIL halt_hold: req/busy/halted=%b, expected 001", {imem_req, busy, halted});
                mismatched++;
            end
        end
        mem[0] = 16'h7000; mem[1] = 16'hF000;
        run_prog(100, 1, 100, w, d);
        compared++;
        if (!(d && w == 1)) begin
            $display("FAIL halt_restart: halted=%b words=%0d, expected halted=1 words=1", d, w);
            mismatched++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem[0] = 16'h3456;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        compared++;
        if ({imem_req, imem_addr} !== {1'b1, START_PC}) begin
            $display("FAIL fetch_wait: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, START_PC);
            mismatched++;
        end
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({imem_req, busy, halted, cw_valid, pc} !== {4'b0, START_PC}) begin
            $display("FAIL reset_mid_fetch: req/busy/halted/valid=%b pc=%h, expected 0000 %h",
                     {imem_req, busy, halted, cw_valid}, pc, START_PC);
            mismatched++;
        end
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0; imem_ack = 1'b1; imem_data = mem[0];
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        compared++;
        if ({cw_valid, cw_sel, cw_rd} !== {1'b1, 4'h3, 4'h4}) begin
            $display("FAIL issue_before_reset: valid=%b sel=%h rd=%h, expected 1 3 4", cw_valid, cw_sel, cw_rd);
            mismatched++;
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({imem_req, busy, halted, cw_valid, cw_write} !== 5'b0) begin
            $display("FAIL reset_mid_issue_ctl: req/busy/halted/valid/write=%b, expected 00000",
                     {imem_req, busy, halted, cw_valid, cw_write});
            mismatched++;
        end
        compared++;
        if ({cw_sel, cw_rd, cw_rs1, cw_rs2, pc} !== {16'h0, START_PC}) begin
            $display("FAIL reset_mid_issue_data: fields=%h pc=%h, expected 0000 %h",
                     {cw_sel, cw_rd, cw_rs1, cw_rs2}, pc, START_PC);
            mismatched++;
        end
        cw_ready = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({imem_req, busy, cw_valid, pc} !== {3'b0, START_PC}) begin
            $display("FAIL no_restart: req/busy/valid=%b pc=%h, expected 000 %h",
                     {imem_req, busy, cw_valid}, pc, START_PC);
            mismatched++;
        end
        cw_ready = 1'b0;
    endtask

    task automatic test_random();
        int w; bit d;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            run_prog(400, 5, 50, w, d);
        end
    endtask

    initial begin
        fill_mem(16'hF000);
        test_reset();
        test_latency();
        test_stall();
        test_jmp();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
